// File: rtl/mt32_seed_init_pkg.sv
// ---------------------------------------------------------------------------
// mt32_seed_init_pkg
// Shared constants for the MT19937 state-RAM seeder: state count, address
// width, the initialisation multiplier and the FSM state encoding. Also holds
// the small fold helper used by the seeding recurrence.
// ---------------------------------------------------------------------------
package mt32_seed_init_pkg;

   localparam int          MT32_N         = 624;
   localparam int          MT32_ADDR_W    = 10;
   localparam logic [31:0] MT32_INIT_MULT = 32'd1812433253;

   // FSM state encoding, kept as plain constants so older blocks that
   // compare against raw codes keep working
   typedef logic [1:0] mt32_state_t;
   localparam mt32_state_t ST_IDLE  = 2'd0;
   localparam mt32_state_t ST_WRITE = 2'd1;
   localparam mt32_state_t ST_FIN   = 2'd2;

   // prev ^ (prev >> 30): the pre-multiply fold of the seeding recurrence
   function automatic logic [31:0] mt32_fold(input logic [31:0] prev);
      return prev ^ {30'b0, prev[31:30]};
   endfunction

endpackage

// File: rtl/mt32_seed_init_if.sv
// ---------------------------------------------------------------------------
// mt32_seed_init_if
// Request and state-RAM write bundle of mt32_seed_init.
//   start, seed             : request side (driven by the master)
//   busy, done, gen_init    : status (driven by the seeder)
//   waddr, wen, wdata       : state RAM write port (driven by the seeder)
// Modports: master = requester / observer, slave = the seeder itself.
// ---------------------------------------------------------------------------
interface mt32_seed_init_if
   import mt32_seed_init_pkg::*;
   #(parameter int ADDR_W = MT32_ADDR_W) ();

   logic              start;
   logic [31:0]       seed;
   logic              busy;
   logic              done;
   logic              gen_init;
   logic [ADDR_W-1:0] waddr;
   logic              wen;
   logic [31:0]       wdata;

   modport master (
      output start, seed,
      input  busy, done, gen_init, waddr, wen, wdata
   );

   modport slave (
      input  start, seed,
      output busy, done, gen_init, waddr, wen, wdata
   );

endinterface

// File: rtl/mt32_seed_init_mul.sv
// ---------------------------------------------------------------------------
// mt32_init_mul
// Computes low32(a * MT32_INIT_MULT) for the seeding recurrence.
// Ports:
//   clk, reset  : only present with MT32_SEED_INIT_MULPIPE_EN
//   in_valid    : operand a is valid this cycle
//   a           : 32-bit operand
//   out_valid   : product is valid
//   product     : low 32 bits of a * MT32_INIT_MULT
// Configuration macro MT32_SEED_INIT_MULPIPE_EN: when defined the product and
// its valid strobe are registered (one cycle latency); otherwise the module
// is purely combinational and out_valid follows in_valid.
// ---------------------------------------------------------------------------
module mt32_init_mul
   import mt32_seed_init_pkg::*;
(
`ifdef MT32_SEED_INIT_MULPIPE_EN
   input  logic        clk,
   input  logic        reset,
`endif
   input  logic        in_valid,
   input  logic [31:0] a,
   output logic        out_valid,
   output logic [31:0] product
);

   logic [31:0] product_comb;

   // Truncating multiply: the 32-bit context keeps only the low word,
   // which is exactly the modulo-2^32 arithmetic the recurrence needs
   always_comb begin
      product_comb = a * MT32_INIT_MULT;
   end

`ifdef MT32_SEED_INIT_MULPIPE_EN
   // Register after the multiplier to break the long multiply path;
   // the valid strobe travels with the data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         product   <= 32'd0;
      end else begin
         out_valid <= in_valid;
         product   <= product_comb;
      end
   end
`else
   assign out_valid = in_valid;
   assign product   = product_comb;
`endif

endmodule

// File: rtl/mt32_seed_init.sv
// ---------------------------------------------------------------------------
// mt32_seed_init
// Seeds the 624-word MT19937 state RAM ahead of mt32_gen:
//   mt[0] = seed, mt[i] = 1812433253*(mt[i-1]^(mt[i-1]>>30)) + i,
// then pulses gen_init (together with done) to start the generator. The
// write port is muxed with the generator's write port; select = busy.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : mt32_seed_init_if.slave (start/seed in; busy/done/gen_init and
//            the waddr/wen/wdata RAM write port out, all registered)
// Parameters: N_WORDS (words written), ADDR_W (RAM address width).
// Configuration macro MT32_SEED_INIT_MULPIPE_EN: registers the multiplier
// output, so each word takes two cycles (wen every other cycle). Written
// values are identical either way.
// ---------------------------------------------------------------------------
module mt32_seed_init
   import mt32_seed_init_pkg::*;
   #(parameter int N_WORDS = MT32_N,
     parameter int ADDR_W  = MT32_ADDR_W)
(
   input  logic             clk,
   input  logic             reset,
   mt32_seed_init_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

   mt32_state_t       state;
   logic              busy_q;
   logic              done_q;
   logic              gen_init_q;
   logic              wen_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;

   logic              mul_in_valid;
   logic              mul_out_valid;
   logic [31:0]       mul_a;
   logic [31:0]       mul_product;
   logic [ADDR_W-1:0] next_addr;
   logic [31:0]       next_index;

   // The recurrence always works from the word just written, so wdata_q
   // doubles as the seed latch and as "prev". A multiply is launched on
   // every cycle a word is being written.
   always_comb begin
      mul_in_valid = (state == ST_WRITE) && wen_q;
      mul_a        = mt32_fold(wdata_q);
      next_addr    = waddr_q + ADDR_W'(1);
      next_index   = 32'(next_addr);
   end

   mt32_init_mul u_mul (
`ifdef MT32_SEED_INIT_MULPIPE_EN
      .clk       (clk),
      .reset     (reset),
`endif
      .in_valid  (mul_in_valid),
      .a         (mul_a),
      .out_valid (mul_out_valid),
      .product   (mul_product)
   );

   // Main FSM. IDLE accepts start and writes the seed on the next cycle.
   // WRITE emits one word each time a product comes back; the last word
   // (address N_WORDS-1) being on the bus moves to FIN, which raises done
   // and gen_init for a single cycle. A start outside IDLE is simply not
   // looked at. The address counter never goes past LAST_ADDR because the
   // exit condition is checked before the increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         gen_init_q <= 1'b0;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q     <= 1'b0;
               gen_init_q <= 1'b0;
               if (bus.start) begin
                  state   <= ST_WRITE;
                  busy_q  <= 1'b1;
                  wen_q   <= 1'b1;
                  waddr_q <= '0;
                  wdata_q <= bus.seed;
               end
            end
            ST_WRITE: begin
               if (wen_q && (waddr_q == LAST_ADDR)) begin
                  state      <= ST_FIN;
                  wen_q      <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  gen_init_q <= 1'b1;
               end else if (mul_out_valid) begin
                  wen_q   <= 1'b1;
                  waddr_q <= next_addr;
                  wdata_q <= mul_product + next_index;
               end else begin
                  wen_q <= 1'b0;
               end
            end
            ST_FIN: begin
               state      <= ST_IDLE;
               done_q     <= 1'b0;
               gen_init_q <= 1'b0;
            end
            default: begin
               state      <= ST_IDLE;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               gen_init_q <= 1'b0;
               wen_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.gen_init = gen_init_q;
   assign bus.wen      = wen_q;
   assign bus.waddr    = waddr_q;
   assign bus.wdata    = wdata_q;

endmodule

// File: tb/tb_mt32_seed_init.sv
// ---------------------------------------------------------------------------
// tb_mt32_seed_init
// Scoreboard bench for mt32_seed_init: each start pushes the full expected
// write sequence (address, data, cycle) and the monitor pops one entry per
// wen. Also checks reset values, done/gen_init timing, ignored starts,
// mid-run reset, and the first three tempered generator outputs derived
// from the words the DUT wrote. Timing follows MT32_SEED_INIT_MULPIPE_EN.
// ---------------------------------------------------------------------------
module tb_mt32_seed_init;
   import mt32_seed_init_pkg::*;

`ifdef MT32_SEED_INIT_MULPIPE_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      int          when;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   wen_cnt = 0;
   int   done_cnt = 0;
   int   exp_done_cyc = -1;
   exp_t sb[$];
   logic [31:0] ram [0:623];

   always #5 clk = ~clk;

   mt32_seed_init_if bus ();

   mt32_seed_init dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running cycle counter; read only on the falling edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] modelNext(input logic [31:0] prev, input int idx);
      logic [31:0] x;
      x = prev ^ (prev >> 30);
      return x * 32'd1812433253 + 32'(idx);
   endfunction

   function automatic logic [31:0] temper(input logic [31:0] v);
      logic [31:0] y;
      y = v;
      y = y ^ (y >> 11);
      y = y ^ ((y << 7) & 32'h9d2c5680);
      y = y ^ ((y << 15) & 32'hefc60000);
      y = y ^ (y >> 18);
      return y;
   endfunction

   // Monitor: every wen pops the scoreboard; done must land on the
   // predicted cycle with gen_init alongside and busy already low
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         checkOutput("gen_init_vs_done", 32'(bus.gen_init), 32'(bus.done));
         if (bus.wen) begin
            wen_cnt++;
            if (bus.waddr < 10'd624) ram[bus.waddr] = bus.wdata;
            if (sb.size() == 0) begin
               checkOutput("unexpected_wen", 32'(bus.wen), 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("waddr", 32'(bus.waddr), 32'(e.addr));
               checkOutput("wdata", bus.wdata, e.data);
               checkOutput("wen_cycle", 32'(cyc), 32'(e.when));
            end
         end
         if (bus.done) begin
            done_cnt++;
            checkOutput("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
            checkOutput("sb_drained", 32'(sb.size()), 32'd0);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] s, output int c);
      logic [31:0] prev;
      @(negedge clk);
      c = cyc;
      bus.seed  = s;
      bus.start = 1'b1;
      prev = s;
      for (int i = 0; i < 624; i++) begin
         sb.push_back('{addr: 10'(i), data: prev, when: c + 1 + STEP * i});
         prev = modelNext(prev, i + 1);
      end
      exp_done_cyc = c + 1 + STEP * 623 + 1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.seed  = $urandom;
   endtask

   task automatic waitDone(input int d0);
      for (int n = 0; n < STEP * 624 + 40; n++) begin
         @(negedge clk);
         if (done_cnt != d0) break;
      end
      repeat (4) @(negedge clk);
      checkOutput("done_count", 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic checkGenOutputs();
      logic [31:0] exp_out [0:2];
      logic [31:0] y;
      logic [31:0] v;
      exp_out[0] = 32'd3499211612;
      exp_out[1] = 32'd581869302;
      exp_out[2] = 32'd3890346734;
      for (int k = 0; k < 3; k++) begin
         y = (ram[k] & 32'h80000000) | (ram[k+1] & 32'h7fffffff);
         v = ram[k+397] ^ (y >> 1) ^ (y[0] ? 32'h9908b0df : 32'd0);
         checkOutput($sformatf("gen_out%0d", k), temper(v), exp_out[k]);
      end
   endtask

   task automatic runSeed5489();
      int c;
      int w0;
      int d0;
      w0 = wen_cnt;
      d0 = done_cnt;
      applyStimulus(32'd5489, c);
      waitDone(d0);
      checkOutput("wen_pulses", 32'(wen_cnt - w0), 32'd624);
      checkOutput("addr0_5489", ram[0], 32'd5489);
      checkOutput("addr1_5489", ram[1], 32'd1301868182);
      checkGenOutputs();
   endtask

   // Watchdog so a stuck DUT still ends the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stim
      int c;
      int w0;
      int d0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.seed  = 32'd0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_gen_init", 32'(bus.gen_init), 32'd0);
      checkOutput("rst_wen", 32'(bus.wen), 32'd0);
      checkOutput("rst_waddr", 32'(bus.waddr), 32'd0);
      checkOutput("rst_wdata", bus.wdata, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] seed 5489");
      runSeed5489();

      $display("[TB] seed 0");
      w0 = wen_cnt;
      d0 = done_cnt;
      applyStimulus(32'd0, c);
      waitDone(d0);
      checkOutput("wen_pulses_s0", 32'(wen_cnt - w0), 32'd624);
      checkOutput("addr0_s0", ram[0], 32'd0);
      checkOutput("addr1_s0", ram[1], 32'd1);
      checkOutput("addr2_s0", ram[2], 32'd1812433255);

      $display("[TB] extra starts while busy and in FIN");
      w0 = wen_cnt;
      d0 = done_cnt;
      applyStimulus(32'd777, c);
      while (cyc < c + 10) @(negedge clk);
      bus.start = 1'b1;
      bus.seed  = 32'd999;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < c + 624) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < exp_done_cyc) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("ignored_done_count", 32'(done_cnt - d0), 32'd1);
      checkOutput("ignored_wen_pulses", 32'(wen_cnt - w0), 32'd624);
      checkOutput("ignored_busy_idle", 32'(bus.busy), 32'd0);

      $display("[TB] reset mid-run");
      d0 = done_cnt;
      applyStimulus(32'd5489, c);
      while (cyc < c + 300) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abort_wen", 32'(bus.wen), 32'd0);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_done", 32'(bus.done), 32'd0);
      checkOutput("abort_waddr", 32'(bus.waddr), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (STEP * 624 + 20) @(negedge clk);
      checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);
      runSeed5489();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
